// File: rtl/demux1x4_seq_pkg.sv
// Shared constants and encodings for the sequential 1-to-4 demultiplexer.
package demux1x4_seq_pkg;

    localparam int NUM_LANES = 4;
    localparam int PTR_W     = 2;

    // Routing mode: fixed select from s1/s0, or round-robin auto-advance.
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/demux1x4_seq_decoder2x4.sv
// 2-to-4 one-hot decoder with enable; produces the lane write enables.
module decoder2x4
    import demux1x4_seq_pkg::*;
(
    input  logic [PTR_W-1:0]     idx,
    input  logic                 en,
    output logic [NUM_LANES-1:0] onehot
);

    // One-hot decode of idx, all zero when not enabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1x4_seq.sv
// Sequential 1-to-4 demultiplexer: routes a serial bit into one of four
// registered lanes, either by explicit select or round-robin, and in
// round-robin mode assembles a 4-bit word at the end of each frame.
//
// Handshake: valid-only stream, no ready. A bit is accepted on every rising
// edge where valid=1, clr=0 and the block is out of reset; there is no
// backpressure, so back-to-back valid cycles are all consumed.
module demux1x4_seq
    import demux1x4_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d,
    input  logic       valid,
    input  logic       mode,
    input  logic       s1,
    input  logic       s0,
    input  logic       clr,
    output logic       o0,
    output logic       o1,
    output logic       o2,
    output logic       o3,
    output logic       v0,
    output logic       v1,
    output logic       v2,
    output logic       v3,
    output logic [1:0] ptr,
    output logic [3:0] q,
    output logic       qv
);

    logic [NUM_LANES-1:0] lane_q, lane_d;
    logic [NUM_LANES-1:0] pulse_q;
    logic [NUM_LANES-1:0] lane_en;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     eff_ptr;
    logic [PTR_W-1:0]     target;
    logic [3:0]           q_q, q_d;
    logic                 qv_q, qv_d;
    mode_e                mode_now;
    mode_e                mode_q;
    logic                 armed_q;
    logic                 mode_chg;
    logic                 accept;
    logic                 frame_end;

    assign mode_now = mode_e'(mode);

    // A mode change restarts the frame: the pointer is treated as 0 on the
    // first edge in the new mode, so a bit accepted there lands in lane 0.
    assign mode_chg = (mode_now != mode_q);
    assign eff_ptr  = mode_chg ? '0 : ptr_q;
    assign target   = (mode_now == MODE_RR) ? eff_ptr : {s1, s0};

    // armed_q keeps the first edge after reset release from accepting a bit.
    assign accept    = valid & ~clr & armed_q;
    assign frame_end = accept & (mode_now == MODE_RR)
                       & (eff_ptr == PTR_W'(NUM_LANES - 1));

    decoder2x4 u_dec (
        .idx    (target),
        .en     (accept),
        .onehot (lane_en)
    );

    // Next-state for lanes, pointer and assembled word; clr wins over data.
    always_comb begin
        lane_d = lane_q;
        ptr_d  = eff_ptr;
        q_d    = q_q;
        qv_d   = 1'b0;
        if (clr) begin
            lane_d = '0;
            ptr_d  = '0;
            q_d    = '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_en[i]) begin
                    lane_d[i] = d;
                end
            end
            if (mode_now == MODE_FIXED) begin
                ptr_d = '0;
            end else if (accept) begin
                ptr_d = eff_ptr + PTR_W'(1);
            end
            if (frame_end) begin
                q_d  = {d, lane_q[2:0]};
                qv_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            pulse_q <= '0;
            ptr_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            mode_q  <= MODE_FIXED;
            armed_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            pulse_q <= lane_en;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            mode_q  <= mode_now;
            armed_q <= 1'b1;
        end
    end

    assign {o3, o2, o1, o0} = lane_q;
    assign {v3, v2, v1, v0} = pulse_q;
    assign ptr              = ptr_q;
    assign q                = q_q;
    assign qv               = qv_q;

endmodule

// File: tb/tb_demux1x4_seq.sv
// Directed, table-driven bench for demux1x4_seq.
module tb_demux1x4_seq;

    logic       clk;
    logic       rst_n;
    logic       d, valid, mode, s1, s0, clr;
    logic       o0, o1, o2, o3, v0, v1, v2, v3;
    logic [1:0] ptr;
    logic [3:0] q;
    logic       qv;

    int checks;
    int failures;

    typedef struct {
        logic       d, valid, mode, s1, s0, clr;
        logic [3:0] o;
        logic [3:0] v;
        logic [1:0] ptr;
        logic [3:0] q;
        logic       qv;
    } vec_t;

    vec_t vecs[30];

    demux1x4_seq dut (
        .clk(clk), .rst_n(rst_n), .d(d), .valid(valid), .mode(mode),
        .s1(s1), .s0(s0), .clr(clr),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3),
        .ptr(ptr), .q(q), .qv(qv)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic vd, logic vv, logic vm, logic vs1, logic vs0,
                                logic vc, logic [3:0] eo, logic [3:0] ev,
                                logic [1:0] ep, logic [3:0] eq, logic eqv);
        vec_t r;
        r.d = vd; r.valid = vv; r.mode = vm; r.s1 = vs1; r.s0 = vs0; r.clr = vc;
        r.o = eo; r.v = ev; r.ptr = ep; r.q = eq; r.qv = eqv;
        return r;
    endfunction

    // {o3..o0, v3..v0, ptr, q, qv}
    function automatic logic [14:0] observed();
        return {o3, o2, o1, o0, v3, v2, v1, v0, ptr, q, qv};
    endfunction

    task automatic check(input string name, input logic [3:0] eo, input logic [3:0] ev,
                         input logic [1:0] ep, input logic [3:0] eq, input logic eqv);
        logic [14:0] act;
        logic [14:0] exp;
        act = observed();
        exp = {eo, ev, ep, eq, eqv};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got o=%b v=%b ptr=%0d q=%b qv=%b, required o=%b v=%b ptr=%0d q=%b qv=%b",
                     name, act[14:11], act[10:7], act[6:5], act[4:1], act[0],
                     eo, ev, ep, eq, eqv);
        end
    endtask

    // driver: set inputs at the falling edge, let one rising edge pass,
    // return at the next falling edge ready for sampling
    task automatic apply(input logic vd, input logic vv, input logic vm,
                         input logic vs1, input logic vs0, input logic vc);
        d = vd; valid = vv; mode = vm; s1 = vs1; s0 = vs0; clr = vc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        d = 0; valid = 0; mode = 0; s1 = 0; s0 = 0; clr = 0;

        //              d v m s1 s0 c   o        v        ptr  q        qv
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 4'b0001, 4'b0001, 2'd0, 4'b0000, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 2'd0, 4'b0000, 0);
        vecs[2]  = mk(1, 1, 0, 0, 1, 0, 4'b0010, 4'b0010, 2'd0, 4'b0000, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 2'd0, 4'b0000, 0);
        vecs[4]  = mk(1, 1, 0, 1, 0, 0, 4'b0100, 4'b0100, 2'd0, 4'b0000, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 2'd0, 4'b0000, 0);
        vecs[6]  = mk(1, 1, 0, 1, 1, 0, 4'b1000, 4'b1000, 2'd0, 4'b0000, 0);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0, 4'b1000, 4'b0000, 2'd0, 4'b0000, 0);
        vecs[8]  = mk(0, 1, 0, 1, 1, 0, 4'b0000, 4'b1000, 2'd0, 4'b0000, 0);
        // round-robin word 1,0,1,1 (selects ignored in mode 1)
        vecs[9]  = mk(1, 1, 1, 1, 1, 0, 4'b0001, 4'b0001, 2'd1, 4'b0000, 0);
        vecs[10] = mk(0, 1, 1, 1, 1, 0, 4'b0001, 4'b0010, 2'd2, 4'b0000, 0);
        vecs[11] = mk(1, 1, 1, 0, 0, 0, 4'b0101, 4'b0100, 2'd3, 4'b0000, 0);
        vecs[12] = mk(1, 1, 1, 0, 0, 0, 4'b1101, 4'b1000, 2'd0, 4'b1101, 1);
        // gaps: valid 1,0,0,1,1,1
        vecs[13] = mk(0, 1, 1, 0, 0, 0, 4'b1100, 4'b0001, 2'd1, 4'b1101, 0);
        vecs[14] = mk(1, 0, 1, 0, 0, 0, 4'b1100, 4'b0000, 2'd1, 4'b1101, 0);
        vecs[15] = mk(1, 0, 1, 0, 0, 0, 4'b1100, 4'b0000, 2'd1, 4'b1101, 0);
        vecs[16] = mk(1, 1, 1, 0, 0, 0, 4'b1110, 4'b0010, 2'd2, 4'b1101, 0);
        vecs[17] = mk(0, 1, 1, 0, 0, 0, 4'b1010, 4'b0100, 2'd3, 4'b1101, 0);
        vecs[18] = mk(1, 1, 1, 0, 0, 0, 4'b1010, 4'b1000, 2'd0, 4'b1010, 1);
        // clr with valid at ptr=2
        vecs[19] = mk(1, 1, 1, 0, 0, 0, 4'b1011, 4'b0001, 2'd1, 4'b1010, 0);
        vecs[20] = mk(1, 1, 1, 0, 0, 0, 4'b1011, 4'b0010, 2'd2, 4'b1010, 0);
        vecs[21] = mk(1, 1, 1, 0, 0, 1, 4'b0000, 4'b0000, 2'd0, 4'b0000, 0);
        // mode switch 1 -> 0 -> 1 at ptr=2
        vecs[22] = mk(1, 1, 1, 0, 0, 0, 4'b0001, 4'b0001, 2'd1, 4'b0000, 0);
        vecs[23] = mk(1, 1, 1, 0, 0, 0, 4'b0011, 4'b0010, 2'd2, 4'b0000, 0);
        vecs[24] = mk(0, 0, 0, 1, 1, 0, 4'b0011, 4'b0000, 2'd0, 4'b0000, 0);
        vecs[25] = mk(0, 1, 1, 0, 0, 0, 4'b0010, 4'b0001, 2'd1, 4'b0000, 0);
        vecs[26] = mk(1, 1, 1, 0, 0, 0, 4'b0010, 4'b0010, 2'd2, 4'b0000, 0);
        vecs[27] = mk(1, 1, 1, 0, 0, 0, 4'b0110, 4'b0100, 2'd3, 4'b0000, 0);
        vecs[28] = mk(1, 1, 1, 0, 0, 0, 4'b1110, 4'b1000, 2'd0, 4'b1110, 1);
        // back to mode 0: q holds, pointer at 0
        vecs[29] = mk(1, 1, 0, 0, 0, 0, 4'b1111, 4'b0001, 2'd0, 4'b1110, 0);

        // reset state
        #1;
        check("reset_state", 4'b0000, 4'b0000, 2'd0, 4'b0000, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // first edge after release: an offered bit must be ignored
        apply(1, 1, 0, 1, 0, 0);
        check("no_accept_on_release", 4'b0000, 4'b0000, 2'd0, 4'b0000, 0);

        for (int i = 0; i < 30; i++) begin
            apply(vecs[i].d, vecs[i].valid, vecs[i].mode, vecs[i].s1, vecs[i].s0, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].o, vecs[i].v, vecs[i].ptr, vecs[i].q, vecs[i].qv);
        end

        // reset mid-frame after two round-robin bits
        apply(1, 1, 1, 0, 0, 0);
        apply(1, 1, 1, 0, 0, 0);
        check("pre_reset_ptr2", 4'b1111, 4'b0010, 2'd2, 4'b1110, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'b0000, 4'b0000, 2'd0, 4'b0000, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 1, 1, 0, 0, 0);
        check("post_reset_first_edge", 4'b0000, 4'b0000, 2'd0, 4'b0000, 0);
        apply(0, 1, 1, 0, 0, 0);
        check("post_reset_bit0", 4'b0000, 4'b0001, 2'd1, 4'b0000, 0);
        apply(1, 1, 1, 0, 0, 0);
        apply(1, 1, 1, 0, 0, 0);
        check("post_reset_bit2", 4'b0110, 4'b0100, 2'd3, 4'b0000, 0);
        apply(0, 1, 1, 0, 0, 0);
        check("post_reset_word", 4'b0110, 4'b1000, 2'd0, 4'b0110, 1);
        apply(1, 0, 1, 0, 0, 0);
        check("qv_single_pulse", 4'b0110, 4'b0000, 2'd0, 4'b0110, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux1x4_seq.md
DEMUX1X4_SEQ -- requirements
Module: demux1x4_seq

Interface
REQ-001 The block SHALL have no parameters; lane count 4 and pointer width 2 are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 d  input  1  serial data bit to route.
REQ-005 valid  input  1  d is meaningful this cycle.
REQ-006 mode  input  1  0 = fixed select from s1/s0; 1 = round-robin auto-advance.
REQ-007 s1  input  1  select MSB (mode 0 only).
REQ-008 s0  input  1  select LSB (mode 0 only).
REQ-009 clr  input  1  synchronous clear of lanes, pointer and word.
REQ-010 o0, o1, o2, o3  output  1 each  registered lane values.
REQ-011 v0, v1, v2, v3  output  1 each  one-cycle pulse: lane written last edge.
REQ-012 ptr  output  2  current round-robin pointer.
REQ-013 q  output  4  assembled word {o3,o2,o1,o0} captured at frame end.
REQ-014 qv  output  1  one-cycle pulse: q updated last edge.

Function
REQ-015 Target lane SHALL be {s1,s0} in mode 0 and ptr in mode 1; lane index n = 2*s1+s0.
REQ-016 On an edge with valid=1 and clr=0, the target lane register SHALL load d and its vN SHALL be 1 for exactly the following cycle; the other lanes SHALL hold.
REQ-017 On an edge with valid=0, all lanes SHALL hold and all vN, qv SHALL be 0.
REQ-018 Latency d -> oN SHALL be one clock edge; no combinational path from inputs to any output.
REQ-019 In mode 1, each accepted bit SHALL advance ptr by 1, wrapping 3 -> 0.
REQ-020 In mode 1, when a bit is accepted with ptr=3, q SHALL load {d,o2,o1,o0} on the same edge and qv SHALL pulse for one cycle.
REQ-021 In mode 0, ptr SHALL hold at 0 and qv SHALL stay 0; q SHALL hold.
REQ-022 A change of mode between edges SHALL reset ptr to 0 on the first edge in the new mode; a bit accepted on that edge in mode 1 SHALL go to lane 0.
REQ-023 clr=1 SHALL take precedence over valid: lanes, ptr and q go to 0, all pulses 0, and the bit is dropped.
REQ-024 Back-to-back valid cycles SHALL be accepted without stall; no backpressure exists.

Reset
REQ-025 While rst_n=0: o0..o3=0, v0..v3=0, ptr=0, q=0, qv=0, and the sampled mode is 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial word; the first accepted bit after release goes to lane 0.
REQ-027 No accepted bit SHALL be taken on the first edge coinciding with rst_n release; the block accepts from the next edge.

Structure
REQ-028 Shared package SHALL hold NUM_LANES=4, PTR_W=2 and the MODE_FIXED/MODE_RR encodings.
REQ-029 Lane enables SHALL come from one sub-module decoder2x4 (2-bit index plus enable in, 4 one-hot enables out), instantiated once.

Verification
REQ-030 Mode 0 sweep: each {s1,s0} in 00..11 with d=1, valid=1 -> only the matching oN=1 and vN pulses; others stay 0.
REQ-031 Mode 1: bits 1,0,1,1 on four consecutive valid cycles -> ptr 1,2,3,0; q=4'b1101, qv pulses once, after the 4th edge.
REQ-032 Mode 1 with gaps: valid 1,0,0,1,1,1 -> ptr advances only on valid cycles; qv after the 6th edge.
REQ-033 clr asserted with valid=1 at ptr=2 -> all outputs 0, ptr=0, no vN pulse, no qv.
REQ-034 rst_n low for one cycle after 2 accepted mode-1 bits -> outputs 0 immediately (asynchronous); the next 4 bits form a full word with q correct.
REQ-035 Mode switch 1 -> 0 -> 1 mid-frame at ptr=2 -> the first mode-1 bit lands in lane 0; no spurious qv.
